// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, source enumeration and entry type for the common data bus arbiter.
// ROB_DEPTH_BITS and DATA_WIDTH may be supplied by the core build; defaults are given here.
`ifndef ROB_DEPTH_BITS
`define ROB_DEPTH_BITS 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC = 3;
  localparam int CDB_TAG_W   = `ROB_DEPTH_BITS;
  localparam int CDB_DATA_W  = `DATA_WIDTH;

  typedef enum logic [1:0] {
    CDB_SRC_ALU    = 2'd0,
    CDB_SRC_LOAD   = 2'd1,
    CDB_SRC_BRANCH = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

  // Reduces idx modulo n for idx < 2*n, which is all a round-robin scan ever needs.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source holding FIFO: circular buffer whose occupancy count doubles as its
// EMPTY / PARTIAL / FULL state. Flush and reset both empty it at the clock edge.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = cdb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  entry_t           enq_entry,
  input  logic             deq,
  output entry_t           head_entry,
  output logic [CNT_W-1:0] count
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             empty;
  logic             do_enq;
  logic             do_deq;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; count_q gates every read, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_entry;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) deq |-> !empty);

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source holding FIFOs, round-robin select and a registered
// broadcast. Define CDB_BYPASS_EN to let an empty source's input win the bus the cycle it arrives.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int  NUM_SRC    = CDB_NUM_SRC,
  parameter int  FIFO_DEPTH = 2,
  parameter int  TAG_W      = CDB_TAG_W,
  parameter int  DATA_W     = CDB_DATA_W,
  localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             in_entry   [NUM_SRC];
  entry_t             head_entry [NUM_SRC];
  logic [CNT_W-1:0]   count      [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_req;
  logic [NUM_SRC-1:0] bypass_req;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] enq;
  logic [NUM_SRC-1:0] deq;

  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   scan_idx;
  entry_t             grant_entry;

  logic [SRC_W-1:0]   rr_ptr_q;
  logic [SRC_W-1:0]   rr_ptr_d;
  logic               cdb_valid_q;
  logic [TAG_W-1:0]   cdb_tag_q;
  logic [DATA_W-1:0]  cdb_data_q;
  logic [SRC_W-1:0]   cdb_src_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic granted;

    assign in_entry[i]  = {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
    assign src_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
    assign fifo_req[i]  = (count[i] != '0);
`ifdef CDB_BYPASS_EN
    assign bypass_req[i] = !fifo_req[i] && src_valid[i];
`else
    assign bypass_req[i] = 1'b0;
`endif
    assign req[i]     = fifo_req[i] || bypass_req[i];
    assign granted    = grant_valid && (grant_idx == SRC_W'(i));
    assign deq[i]     = granted && fifo_req[i];
    // A bypass winner goes straight to the bus and must not also land in its FIFO.
    assign enq[i]     = src_valid[i] && src_ready[i] && !(granted && bypass_req[i]);

    cdb_src_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .enq        (enq[i]),
      .enq_entry  (in_entry[i]),
      .deq        (deq[i]),
      .head_entry (head_entry[i]),
      .count      (count[i])
    );

    a_src_protocol: assert property (@(posedge clk) disable iff (rst)
      !(src_valid[i] && !src_ready[i]));
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = SRC_W'(rr_wrap(int'(rr_ptr_q) + k, NUM_SRC));
      if (!grant_valid && req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    grant_entry = fifo_req[grant_idx] ? head_entry[grant_idx] : in_entry[grant_idx];
    rr_ptr_d    = grant_valid ? SRC_W'(rr_wrap(int'(grant_idx) + 1, NUM_SRC)) : rr_ptr_q;
  end

  // Flush cancels the broadcast but deliberately leaves rr_ptr where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_valid_q <= grant_valid;
      rr_ptr_q    <= rr_ptr_d;
      if (grant_valid) begin
        cdb_tag_q  <= grant_entry.tag;
        cdb_data_q <= grant_entry.data;
        cdb_src_q  <= grant_idx;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

  a_src_in_range: assert property (@(posedge clk) disable iff (rst)
    cdb_valid_q |-> (int'(cdb_src_q) < NUM_SRC));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed broadcasts. Honours CDB_BYPASS_EN if defined.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = CDB_NUM_SRC;
  localparam int D  = 2;
  localparam int TW = CDB_TAG_W;
  localparam int DW = CDB_DATA_W;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*TW-1:0] src_tag = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one queue per source ----------------
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq [N][$];
  bit            live = 1'b0;
  bit            m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_rr;
  int            win;
  int            taken;
  bit            rdy_pre [N];
  ent_t          e;

  function automatic ent_t in_ent(input int i);
    return {src_tag[i*TW +: TW], src_data[i*DW +: DW]};
  endfunction

  function automatic bit wants(input int i);
    return (mq[i].size() > 0) || (BYP && src_valid[i]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_src = 0;
      live = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_valid = 0;
    end else begin
      for (int i = 0; i < N; i++) rdy_pre[i] = (mq[i].size() < D);
      win = -1;
      taken = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && wants((m_rr + k) % N)) win = (m_rr + k) % N;
      if (win >= 0) begin
        if (mq[win].size() > 0) e = mq[win].pop_front();
        else begin e = in_ent(win); taken = win; end
        m_valid = 1; m_tag = e.tag; m_data = e.data; m_src = win;
        m_rr = (win + 1) % N;
      end else begin
        m_valid = 0;
      end
      for (int i = 0; i < N; i++)
        if (src_valid[i] && rdy_pre[i] && i != taken) mq[i].push_back(in_ent(i));
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("cyc_valid", cdb_valid, m_valid);
      check("cyc_tag", cdb_tag, m_tag);
      check("cyc_data", cdb_data, m_data);
      check("cyc_src", cdb_src, m_src);
      for (int i = 0; i < N; i++) check("cyc_ready", src_ready[i], mq[i].size() < D);
    end
  end

  // ---------------- broadcast log for directed expectations ----------------
  typedef struct {
    int            src;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } bc_t;
  bc_t bq[$];

  always @(negedge clk) begin
    if (cdb_valid === 1'b1) bq.push_back('{src: int'(cdb_src), tag: cdb_tag, data: cdb_data});
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    src_valid[i] = 1'b1;
    src_tag[i*TW +: TW] = t;
    src_data[i*DW +: DW] = d;
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; idle();
    cyc(); cyc();
    rst = 1'b0;
    bq.delete();
  endtask

  task automatic expect_bcast(input string name, input int src, input int tag, input logic [DW-1:0] data);
    int n = 0;
    bc_t b;
    while (bq.size() == 0 && n < 20) begin cyc(); n++; end
    check({name, "_arrived"}, bq.size() > 0, 1'b1);
    if (bq.size() > 0) begin
      b = bq.pop_front();
      check({name, "_src"}, b.src, src);
      check({name, "_tag"}, b.tag, tag);
      check({name, "_data"}, b.data, data);
    end
  endtask

  task automatic fill_all(input int cycles, inout int k0, inout int k2);
    for (int c = 0; c < cycles; c++) begin
      idle();
      if (mq[0].size() < D) begin drive(0, TW'(k0), 32'hA000_0000 | k0); k0++; end
      if (mq[2].size() < D) begin drive(2, TW'(k2), 32'hC000_0000 | k2); k2++; end
      cyc();
    end
    idle();
  endtask

  initial begin
    int k0, k2, n0, n2;

    // Reset state
    do_reset();
    check("rst_valid", cdb_valid, 1'b0);
    check("rst_tag", cdb_tag, 0);
    check("rst_data", cdb_data, 0);
    check("rst_src", cdb_src, 0);
    check("rst_ready", src_ready, 3'b111);

    // Single ALU push: latency 2 edges (1 with bypass)
    drive(CDB_SRC_ALU, 4'd3, 32'h11);
    cyc();
    idle();
`ifdef CDB_BYPASS_EN
    check("t1_early_valid", cdb_valid, 1'b1);
`else
    check("t1_early_valid", cdb_valid, 1'b0);
    cyc();
    check("t1_late_valid", cdb_valid, 1'b1);
`endif
    check("t1_tag", cdb_tag, 3);
    check("t1_data", cdb_data, 32'h11);
    check("t1_src", cdb_src, 0);
    cyc();
    check("t1_idle_valid", cdb_valid, 1'b0);

    // All three at once from rr_ptr = 0
    do_reset();
    drive(0, 4'd1, 32'hA1); drive(1, 4'd2, 32'hB2); drive(2, 4'd3, 32'hC3);
    cyc();
    idle();
    expect_bcast("t2_a", 0, 1, 32'hA1);
    expect_bcast("t2_b", 1, 2, 32'hB2);
    expect_bcast("t2_c", 2, 3, 32'hC3);
    // rr_ptr back at 0: ALU beats branch when both arrive together
    drive(2, 4'd4, 32'hC4); drive(0, 4'd5, 32'hA5);
    cyc();
    idle();
    expect_bcast("t2_rr0", 0, 5, 32'hA5);
    expect_bcast("t2_rr2", 2, 4, 32'hC4);

    // Load back-to-back, others idle
    drive(1, 4'd4, 32'h44);
    cyc();
    drive(1, 4'd5, 32'h55);
    cyc();
    idle();
    expect_bcast("t3_first", 1, 4, 32'h44);
    expect_bcast("t3_second", 1, 5, 32'h55);

    // Flush with buffered entries and a same-cycle ALU push
    do_reset();
    drive(0, 4'd1, 32'hA1); drive(1, 4'd2, 32'hB2); drive(2, 4'd3, 32'hC3);
    cyc();
    idle();
    drive(0, 4'd4, 32'hA4); drive(2, 4'd5, 32'hC5);
    cyc();
    idle();
    flush = 1'b1;
    drive(0, 4'd9, 32'h99);
    cyc();
    flush = 1'b0;
    idle();
    check("t4_valid", cdb_valid, 1'b0);
    check("t4_ready", src_ready, 3'b111);
    bq.delete();
    repeat (6) cyc();
    check("t4_no_bcast", bq.size(), 0);

    // ALU and branch continuously valid, load idle
    bq.delete();
    k0 = 0; k2 = 0;
    fill_all(16, k0, k2);
    repeat (8) cyc();
    check("t5_all_delivered", bq.size(), k0 + k2);
    check("t5_enough", bq.size() >= 8, 1'b1);
    n0 = 0; n2 = 0;
    for (int j = 0; j < bq.size(); j++) begin
      if (j > 0 && j < 8) check("t5_alternate", bq[j].src != bq[j-1].src, 1'b1);
      if (bq[j].src == 0) begin
        check("t5_order_alu", bq[j].tag, n0 % 16);
        check("t5_data_alu", bq[j].data, 32'hA000_0000 | n0);
        n0++;
      end else begin
        check("t5_src_branch", bq[j].src, 2);
        check("t5_order_br", bq[j].tag, n2 % 16);
        check("t5_data_br", bq[j].data, 32'hC000_0000 | n2);
        n2++;
      end
    end

    // Reset in the middle of a burst
    k0 = 0; k2 = 0;
    fill_all(4, k0, k2);
    drive(1, 4'd6, 32'hB6);
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    check("t6_valid", cdb_valid, 1'b0);
    check("t6_tag", cdb_tag, 0);
    check("t6_data", cdb_data, 0);
    check("t6_src", cdb_src, 0);
    check("t6_ready", src_ready, 3'b111);
    rst = 1'b0;
    bq.delete();
    drive(2, 4'd8, 32'h88); drive(0, 4'd7, 32'h77);
    cyc();
    idle();
    expect_bcast("t6_post_a", 0, 7, 32'h77);
    expect_bcast("t6_post_b", 2, 8, 32'h88);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
